mem_port_client: RTL

//  Per-core requester for the shared 4-core memory's arbitrated read port (port 4) and write port.
//  The memory arbitrates with fixed priority A>B>C>D and silently drops losing requests.

---
 rtl/mem_pkg.sv | 31 +++
 rtl/mem_port_client.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the arbitrated memory port client.
// State encoding, core tags and memory address field positions.
package mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_CHECK,
    S_WR_ISSUE,
    S_VF_ISSUE,
    S_VF_WAIT,
    S_VF_CHECK
  } state_e;

  localparam logic [1:0] CORE_A = 2'd0;
  localparam logic [1:0] CORE_B = 2'd1;
  localparam logic [1:0] CORE_C = 2'd2;
  localparam logic [1:0] CORE_D = 2'd3;

  localparam int ADDR_VLD = 16;
  localparam int RD_LAT   = 2;
  localparam int AW       = 15;
  localparam int DW       = 16;

  // Saturating increment for the 8-bit retry counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mem_port_client.sv
// Per-core requester for the shared memory's arbitrated read/write ports.
// Serialises loads/stores, detects dropped accesses, retries to a budget.
module mem_port_client
  import mem_pkg::*;
#(
  parameter logic [1:0] CORE_ID     = CORE_A,
  parameter logic [7:0] MAX_RETRIES = 8'd255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic          req_write,
  input  logic [15:1]   req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          req_ready,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic [16:1]   raddr4,
  input  logic [17:0]   rdata4,
  output logic [16:1]   waddr,
  output logic [DW-1:0] wdata
);

  state_e        state_q, state_d;
  logic [15:1]   addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [7:0]    cnt_q, cnt_d;

  logic tag_ok;
  logic data_ok;
  logic at_limit;

  assign tag_ok   = (rdata4[17:16] == CORE_ID);
  assign data_ok  = (rdata4[DW-1:0] == data_q);
  assign at_limit = (cnt_q >= MAX_RETRIES);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          data_d  = req_wdata;
          cnt_d   = '0;
          state_d = req_write ? S_WR_ISSUE : S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT:  state_d = S_RD_CHECK;
      S_RD_CHECK: begin
        unique case (1'b1)
          tag_ok: begin
            resp_valid = 1'b1;
            resp_rdata = rdata4[DW-1:0];
            state_d    = S_IDLE;
          end
          at_limit: begin
            resp_valid = 1'b1;
            resp_err   = 1'b1;
            state_d    = S_IDLE;
          end
          default: begin
            cnt_d   = sat_inc(cnt_q);
            state_d = S_RD_ISSUE;
          end
        endcase
      end
      S_WR_ISSUE: state_d = S_VF_ISSUE;
      S_VF_ISSUE: state_d = S_VF_WAIT;
      S_VF_WAIT:  state_d = S_VF_CHECK;
      S_VF_CHECK: begin
        unique case (1'b1)
          (tag_ok && data_ok): begin
            resp_valid = 1'b1;
            state_d    = S_IDLE;
          end
          at_limit: begin
            resp_valid = 1'b1;
            resp_err   = 1'b1;
            state_d    = S_IDLE;
          end
          default: begin
            // Lost read arbitration: re-read only; lost the write: rewrite.
            cnt_d   = sat_inc(cnt_q);
            state_d = tag_ok ? S_WR_ISSUE : S_VF_ISSUE;
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic rd_en;
  logic wr_en;

  assign rd_en = (state_q == S_RD_ISSUE) || (state_q == S_VF_ISSUE);
  assign wr_en = (state_q == S_WR_ISSUE);

  assign req_ready = (state_q == S_IDLE);
  assign raddr4    = rd_en ? {1'b1, addr_q} : '0;
  assign waddr     = wr_en ? {1'b1, addr_q} : '0;
  assign wdata     = wr_en ? data_q : '0;

endmodule
